m_uart_loader: RTL and testbench

Serial program loader that sits directly upstream of the pipelined processor and its instruction/data memory. It receives a program image over a UART line (8N1), assembles little-endian 32-bit words and writes them sequentially into memory from word address 0. It holds the processor in reset until the image is complete, so new programs load without resynthesising memory initialisers.

---
 rtl/m_uart_loader_pkg.sv | 25 ++
 rtl/m_uart_loader_rx.sv | 99 +++++++++
 rtl/m_uart_loader.sv | 124 ++++++++++++
 tb/tb_m_uart_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_uart_loader_pkg.sv
// Shared constants and state encodings for the UART program loader and its receiver.
package m_uart_loader_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_WORDS        = 4096;
  localparam int SYNC_STAGES      = 2;

  // Loader FSM encoding
  localparam logic [1:0] S_HDR0 = 2'd0;
  localparam logic [1:0] S_HDR1 = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Receiver FSM encoding
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  // Bytes enter at the top so that after four pushes the first byte sits in bits 7:0.
  function automatic logic [31:0] f_push_byte(input logic [31:0] word, input logic [7:0] b);
    return {b, word[31:8]};
  endfunction

endpackage

// File: rtl/m_uart_loader_rx.sv
// 8N1 UART receiver: input synchroniser, mid-bit sampling, byte strobe and framing-error strobe.
module m_uart_rx
  import m_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic       w_rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       ferr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rxd_s;
  logic                   rxd_prev_reg;
  logic [1:0]             state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [2:0]             bit_idx_reg;
  logic [7:0]             shift_reg;

  assign rxd_s = sync_reg[SYNC_STAGES-1];

  // Line idles high, so the synchroniser resets to 1 to avoid a phantom start edge.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      sync_reg     <= '1;
      rxd_prev_reg <= 1'b1;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], w_rxd};
      rxd_prev_reg <= rxd_s;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_reg   <= R_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      ferr        <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      ferr       <= 1'b0;
      case (state_reg)
        R_IDLE: begin
          if (rxd_prev_reg && !rxd_s) begin
            state_reg <= R_START;
            cnt_reg   <= '0;
          end
        end
        R_START: begin
          if (cnt_reg == HALF_M1) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            // A line that is high again at mid-start was only a glitch.
            state_reg   <= rxd_s ? R_IDLE : R_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt_reg == FULL_M1) begin
            cnt_reg     <= '0;
            shift_reg   <= {rxd_s, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == 3'd7) state_reg <= R_STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        R_STOP: begin
          if (cnt_reg == FULL_M1) begin
            cnt_reg   <= '0;
            // Re-arm at mid-stop so a start bit right after the stop bit is caught.
            state_reg <= R_IDLE;
            if (rxd_s) begin
              byte_valid <= 1'b1;
              byte_data  <= shift_reg;
            end else begin
              ferr <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/m_uart_loader.sv
// Program loader: 16-bit word count header, then little-endian words written from address 0.
module m_uart_loader
  import m_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int WORDS        = DEF_WORDS,
  parameter int ADDR_W       = $clog2(WORDS)
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_rxd,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [31:0]       r_wdata,
  output logic              r_busy,
  output logic              r_done,
  output logic              r_err
);

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        ferr;

  m_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .w_clk     (w_clk),
    .w_rst     (w_rst),
    .w_rxd     (w_rxd),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .ferr      (ferr)
  );

  logic [1:0]  state_reg;
  logic [7:0]  n_lo_reg;
  logic [15:0] n_reg;
  logic [1:0]  byte_cnt_reg;
  logic [31:0] word_reg;
  logic [15:0] word_cnt_reg;
  logic        finish_reg;

  logic [15:0] hdr_n;
  logic [31:0] word_next;
  logic        last_word;

  assign hdr_n     = {byte_data, n_lo_reg};
  assign word_next = f_push_byte(word_reg, byte_data);
  assign last_word = ((word_cnt_reg + 16'd1) == n_reg);

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_reg    <= S_HDR0;
      n_lo_reg     <= '0;
      n_reg        <= '0;
      byte_cnt_reg <= '0;
      word_reg     <= '0;
      word_cnt_reg <= '0;
      finish_reg   <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      if (ferr && state_reg != S_DONE) begin
        // Abandon the whole image; whatever was already written stays in memory.
        r_err        <= 1'b1;
        state_reg    <= S_HDR0;
        n_lo_reg     <= '0;
        n_reg        <= '0;
        byte_cnt_reg <= '0;
        word_reg     <= '0;
        word_cnt_reg <= '0;
        finish_reg   <= 1'b0;
        r_addr       <= '0;
      end else if (finish_reg) begin
        // Deferred one cycle so done never coincides with the final write strobe.
        finish_reg <= 1'b0;
        r_done     <= 1'b1;
        r_busy     <= 1'b0;
        state_reg  <= S_DONE;
      end else if (byte_valid) begin
        case (state_reg)
          S_HDR0: begin
            n_lo_reg  <= byte_data;
            state_reg <= S_HDR1;
          end
          S_HDR1: begin
            n_reg        <= hdr_n;
            byte_cnt_reg <= '0;
            word_cnt_reg <= '0;
            if (hdr_n == 16'd0) begin
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              state_reg <= S_DONE;
            end else if ({16'd0, hdr_n} > 32'(WORDS)) begin
              r_err     <= 1'b1;
              state_reg <= S_HDR0;
            end else begin
              state_reg <= S_DATA;
            end
          end
          S_DATA: begin
            word_reg     <= word_next;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              r_we         <= 1'b1;
              r_addr       <= word_cnt_reg[ADDR_W-1:0];
              r_wdata      <= word_next;
              word_cnt_reg <= word_cnt_reg + 16'd1;
              if (last_word) finish_reg <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m_uart_loader.sv
// Self-checking bench for m_uart_loader: directed scenarios plus random images against a word-list model.
module tb_m_uart_loader;

  localparam int CPB    = 4;
  localparam int WORDS  = 4096;
  localparam int ADDR_W = 12;

  logic              w_clk = 1'b0;
  logic              w_rst = 1'b1;
  logic              w_rxd = 1'b1;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  m_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .WORDS       (WORDS),
    .ADDR_W      (ADDR_W)
  ) dut (
    .w_clk  (w_clk),
    .w_rst  (w_rst),
    .w_rxd  (w_rxd),
    .r_we   (r_we),
    .r_addr (r_addr),
    .r_wdata(r_wdata),
    .r_busy (r_busy),
    .r_done (r_done),
    .r_err  (r_err)
  );

  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Observed bus activity
  logic [ADDR_W-1:0] wr_a_q[$];
  logic [31:0]       wr_d_q[$];
  int                done_cnt    = 0;
  int                overlap_cnt = 0;
  int                done_busy   = 0;

  always @(negedge w_clk) begin
    if (!w_rst) begin
      if (r_we) begin
        wr_a_q.push_back(r_addr);
        wr_d_q.push_back(r_wdata);
        $display("write addr=%0d data=0x%08h", r_addr, r_wdata);
      end
      if (r_done) done_cnt++;
      if (r_we && r_done) overlap_cnt++;
      if (r_done && r_busy) done_busy++;
    end
  end

  // Stimulus and expectations
  logic [7:0]        tx_q[$];
  logic [ADDR_W-1:0] exp_a_q[$];
  logic [31:0]       exp_d_q[$];

  task automatic tick(input int n);
    repeat (n) @(negedge w_clk);
  endtask

  task automatic send_bit(input logic v);
    w_rxd = v;
    repeat (CPB) @(negedge w_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    if (!stop) begin
      w_rxd = 1'b1;
      tick(3 * CPB);
    end
  endtask

  task automatic send_q(input bit random_gaps);
    int gap;
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], 1'b1);
      gap = random_gaps ? int'($urandom_range(0, 3)) : 0;
      if (gap > 0) begin
        w_rxd = 1'b1;
        tick(gap);
      end
    end
    tx_q.delete();
  endtask

  task automatic clear_obs();
    wr_a_q.delete();
    wr_d_q.delete();
    exp_a_q.delete();
    exp_d_q.delete();
    done_cnt    = 0;
    overlap_cnt = 0;
    done_busy   = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge w_clk);
    w_rst = 1'b1;
    w_rxd = 1'b1;
    @(negedge w_clk);
    w_rst = 1'b0;
    check_val({tag, "_rst_we"},    r_we,    1'b0);
    check_val({tag, "_rst_addr"},  r_addr,  '0);
    check_val({tag, "_rst_wdata"}, r_wdata, '0);
    check_val({tag, "_rst_busy"},  r_busy,  1'b1);
    check_val({tag, "_rst_done"},  r_done,  1'b0);
    check_val({tag, "_rst_err"},   r_err,   1'b0);
    clear_obs();
  endtask

  // Reference model: an image is a word count plus a word list; memory gets word i at address i.
  task automatic model_image(input logic [15:0] n);
    logic [31:0] w;
    tx_q.push_back(n[7:0]);
    tx_q.push_back(n[15:8]);
    for (int i = 0; i < int'(n); i++) begin
      w = $urandom;
      exp_a_q.push_back(ADDR_W'(i));
      exp_d_q.push_back(w);
      for (int k = 0; k < 4; k++) tx_q.push_back(8'((w >> (8 * k)) & 32'hFF));
    end
  endtask

  task automatic check_result(input string tag, input int exp_done, input logic exp_busy,
                              input logic exp_err);
    int n;
    tick(14);
    check_val({tag, "_nwr"}, wr_a_q.size(), exp_a_q.size());
    n = (wr_a_q.size() < exp_a_q.size()) ? wr_a_q.size() : exp_a_q.size();
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s_addr%0d", tag, i), wr_a_q[i], exp_a_q[i]);
      check_val($sformatf("%s_data%0d", tag, i), wr_d_q[i], exp_d_q[i]);
    end
    check_val({tag, "_done"},    done_cnt, exp_done);
    check_val({tag, "_busy"},    r_busy,   exp_busy);
    check_val({tag, "_err"},     r_err,    exp_err);
    check_val({tag, "_overlap"}, overlap_cnt, 0);
    check_val({tag, "_donebusy"}, done_busy, 0);
    $display("scenario %s: writes=%0d done=%0d busy=%0b err=%0b", tag, wr_a_q.size(), done_cnt,
             r_busy, r_err);
  endtask

  task automatic push_scen1();
    tx_q = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h44};
    exp_a_q.push_back(12'd0);
    exp_d_q.push_back(32'h00000020);
    exp_a_q.push_back(12'd1);
    exp_d_q.push_back(32'h44000011);
  endtask

  initial begin
    // Hang guard
    #500000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tick(3);

    // 1: two-word image
    do_reset("s1");
    push_scen1();
    send_q(1'b0);
    check_result("s1", 1, 1'b0, 1'b0);

    // 2: empty image, then extra bytes must be ignored in S_DONE
    do_reset("s2");
    tx_q = '{8'h00, 8'h00};
    send_q(1'b0);
    check_result("s2", 1, 1'b0, 1'b0);
    tx_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_q(1'b0);
    check_result("s2_ign", 1, 1'b0, 1'b0);

    // 3: oversize count rejected, then a good image with r_err still set
    do_reset("s3");
    tx_q = '{8'h01, 8'h10};
    send_q(1'b0);
    check_result("s3_over", 0, 1'b1, 1'b1);
    push_scen1();
    send_q(1'b0);
    check_result("s3_load", 1, 1'b0, 1'b1);

    // 3b: N=WORDS exactly is accepted (stays busy, no error)
    do_reset("s3b");
    tx_q = '{8'h00, 8'h10};
    send_q(1'b0);
    check_result("s3b", 0, 1'b1, 1'b0);

    // 4: framing error mid-word, then recovery from address 0
    do_reset("s4");
    tx_q = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send_q(1'b0);
    send_byte(8'h5A, 1'b0);
    check_result("s4_ferr", 0, 1'b1, 1'b1);
    tx_q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    exp_a_q.push_back(12'd0);
    exp_d_q.push_back(32'h12345678);
    send_q(1'b0);
    check_result("s4_load", 1, 1'b0, 1'b1);

    // 5: one-cycle glitch is not a byte; header parsing must still start cleanly
    do_reset("s5");
    w_rxd = 1'b0;
    tick(1);
    w_rxd = 1'b1;
    tick(6 * CPB);
    check_result("s5_glitch", 0, 1'b1, 1'b0);
    tx_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_a_q.push_back(12'd0);
    exp_d_q.push_back(32'hDEADBEEF);
    send_q(1'b0);
    check_result("s5_load", 1, 1'b0, 1'b0);

    // 6: reset mid-load discards the partial word
    do_reset("s6");
    tx_q = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send_q(1'b0);
    tick(6);
    check_val("s6_prewr", wr_a_q.size(), 0);
    do_reset("s6_mid");
    tx_q = '{8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
    exp_a_q.push_back(12'd0);
    exp_d_q.push_back(32'h01020304);
    send_q(1'b0);
    check_result("s6_load", 1, 1'b0, 1'b0);

    // Random images with random inter-byte gaps (including back-to-back)
    for (int it = 0; it < 6; it++) begin
      do_reset($sformatf("rnd%0d", it));
      n = int'($urandom_range(1, 6));
      model_image(16'(n));
      send_q(1'b1);
      check_result($sformatf("rnd%0d", it), 1, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
